// File: rtl/fft_input_loader.sv
// fft_input_loader
//
// Takes a 64-sample complex frame from an upstream valid/ready stream and
// writes each sample into the FFT core's working memory. Samples go to the
// bit-reversed address (BITREV=1) or to natural order (BITREV=0). When the
// frame is complete, the loader pulses fft_start. It then stalls the stream
// until the core answers with fft_done.
//
// Ports
//   clk, rst            clock; synchronous active-low reset
//   in_valid/in_ready   upstream handshake (in_ready high only in LOAD)
//   in_re, in_im        sample components, DATA_W bits each
//   in_last             upstream end-of-frame marker
//   wr_en/wr_addr/wr_data  registered memory write port, data packed {re, im}
//   fft_start           one-cycle pulse: frame loaded
//   fft_done            core finished the current frame (honoured only in WAIT)
//   frame_err           one-cycle pulse, aligned with the write of a sample
//                       whose in_last disagrees with its position
//   busy                frame partially loaded or being processed
//   sample_cnt          samples accepted so far in the current frame
module fft_input_loader #(
  parameter int DATA_W = 16,
  parameter int BITREV = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_re,
  input  logic [DATA_W-1:0]   in_im,
  input  logic                in_last,
  output logic                wr_en,
  output logic [5:0]          wr_addr,
  output logic [2*DATA_W-1:0] wr_data,
  output logic                fft_start,
  input  logic                fft_done,
  output logic                frame_err,
  output logic                busy,
  output logic [5:0]          sample_cnt
);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_FLUSH = 2'd1,
    S_START = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [5:0]  cnt, cnt_nxt;
  logic        accept_p0;
  logic        err_p0;

  logic                vld_p1;
  logic [5:0]          addr_p1;
  logic [2*DATA_W-1:0] data_p1;
  logic                err_p1;
  logic                start_p1;

  function automatic logic [5:0] mem_index(input logic [5:0] idx);
    logic [5:0] r;
    r = idx;
    if (BITREV != 0) begin
      for (int i = 0; i < 6; i++) r[i] = idx[5-i];
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_LOAD;
      cnt   <= 6'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_LOAD: begin
        if (accept_p0) begin
          if (cnt == 6'd63) begin
            state_nxt = S_FLUSH;
            cnt_nxt   = 6'd0;
          end else if (in_last) begin
            // Early end-of-frame aborts the frame; the loader stays in LOAD.
            cnt_nxt   = 6'd0;
          end else begin
            cnt_nxt   = cnt + 6'd1;
          end
        end
      end
      S_FLUSH: state_nxt = S_START;
      S_START: state_nxt = S_WAIT;
      S_WAIT:  if (fft_done) state_nxt = S_LOAD;
      default: state_nxt = S_LOAD;
    endcase
  end

  always_comb begin
    in_ready   = (state == S_LOAD);
    busy       = (state != S_LOAD) || (cnt != 6'd0);
    sample_cnt = cnt;
    accept_p0  = in_valid && (state == S_LOAD);
    // Missing last on sample 63 or early last elsewhere.
    err_p0     = accept_p0 && (in_last != (cnt == 6'd63));
  end

  // p0 -> p1: register the write, error flag and start pulse
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p1   <= 1'b0;
      err_p1   <= 1'b0;
      start_p1 <= 1'b0;
      addr_p1  <= 6'd0;
      data_p1  <= '0;
    end else begin
      vld_p1   <= accept_p0;
      err_p1   <= err_p0;
      start_p1 <= (state_nxt == S_START);
      if (accept_p0) begin
        addr_p1 <= mem_index(cnt);
        data_p1 <= {in_re, in_im};
      end
    end
  end

  assign wr_en     = vld_p1;
  assign wr_addr   = addr_p1;
  assign wr_data   = data_p1;
  assign frame_err = err_p1;
  assign fft_start = start_p1;

endmodule

// File: doc/fft_input_loader.md
# fft_input_loader

Input-side companion to the FFT output counter. Accepts a stream of 64 complex samples over a valid/ready handshake and writes each into the FFT core's working memory at its bit-reversed address. Pulses `fft_start` once the frame is complete, then blocks new input until the core reports `fft_done`. It sits between the upstream sample source and the FFT core's load port.

## Interface

- `DATA_W`, default 16: width of each real and imaginary component.
- `BITREV`, default 1: 1 selects a bit-reversed write address; 0 selects natural order.

- `clk`  in  1  system clock; all logic updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-low. 0 = reset.
- `in_valid`  in  1  upstream sample present.
- `in_ready`  out  1  loader can accept; equals (state == LOAD).
- `in_re`  in  DATA_W  sample real part.
- `in_im`  in  DATA_W  sample imaginary part.
- `in_last`  in  1  upstream marks the 64th sample of a frame.
- `wr_en`  out  1  memory write strobe.
- `wr_addr`  out  6  memory write address.
- `wr_data`  out  2*DATA_W  write data, packed {re, im}.
- `fft_start`  out  1  one-cycle pulse: frame is loaded.
- `fft_done`  in  1  core finished the current frame.
- `frame_err`  out  1  one-cycle pulse: `in_last` misaligned with the sample count.
- `busy`  out  1  a frame is partially loaded or being processed.
- `sample_cnt`  out  6  number of samples accepted in the current frame.

## Operation

- An accept occurs on a rising edge where `in_valid` & `in_ready` = 1.
- State machine has four states:
  - LOAD: `in_ready` = 1.
    - Each accept registers the write and increments `cnt` (6-bit).
    - The accept with `cnt` = 63 goes to FLUSH, and `cnt` wraps to 0.
  - FLUSH: one cycle; the final write is in flight. `in_ready` = 0. Goes to START.
  - START: one cycle; `fft_start` = 1. Goes to WAIT.
  - WAIT: holds until `fft_done` = 1 is sampled, then goes to LOAD.
- `fft_done` is ignored in LOAD, FLUSH and START.
- Write address: `wr_addr` = `BITREV` ? bit-reverse(`cnt`) : `cnt`. Examples: 0→0, 1→32, 2→16, 3→48, 62→31, 63→63.
- `wr_data` = {`in_re`, `in_im`}, passed through unmodified. No arithmetic is applied.
- Early `in_last` (`in_last` = 1 on an accept with `cnt` ≠ 63):
  - The sample is still written.
  - `frame_err` pulses.
  - The frame is aborted: `cnt` resets to 0, the state stays LOAD, and no `fft_start` is issued.
- Missing `in_last` (`in_last` = 0 on the accept with `cnt` = 63):
  - The frame completes normally through FLUSH and START.
  - `frame_err` pulses.
- `busy` = (state ≠ LOAD) | (`cnt` ≠ 0).
- `sample_cnt` = `cnt`.
- `fft_start` is a registered output, decoded from state START.

## Timing

- Reset (`rst` = 0 at an edge) applies the following after that edge:
  - state = LOAD, so `in_ready` = 1.
  - `cnt` = 0.
  - `wr_en`, `wr_addr`, `wr_data`, `fft_start`, `frame_err`, `busy` are all 0.
- Reset mid-operation:
  - Takes priority over all other inputs.
  - A write registered on the reset edge is dropped: `wr_en` = 0 in the following cycle.
  - A partially loaded frame is discarded, and no `fft_start` is issued for it.
- Write latency: an accept at edge E gives `wr_en` = 1 with its address and data during cycle E..E+1. Back-to-back accepts give a continuous `wr_en`.
- Frame completion: 64th accept at edge E.
  - Cycle after E: final write and FLUSH, with `in_ready` = 0.
  - Next cycle: START, with `fft_start` = 1.
  - Then WAIT.
- End-to-end: `fft_start` rises exactly 2 cycles after the edge of the 64th accept. It stays high for exactly 1 cycle.
- `fft_done` sampled high at edge D in WAIT: `in_ready` = 1 from cycle D..D+1. Best case is 64 samples per 67 cycles plus core latency.
- `frame_err` is high for one cycle, aligned with the `wr_en` of the offending sample.
- `in_valid` = 1 while `in_ready` = 0 is not an accept. Data must be held upstream; the loader counts no sample.

## Test plan

- Reset, then 64 back-to-back samples (re = k, im = -k, `in_last` on k = 63) → writes appear one cycle after each accept, at addresses 0, 32, 16, 48, …, 63, with data {k, -k}. `fft_start` pulses 2 cycles after the 64th accept; `in_ready` = 0 until `fft_done`.
- Same frame with random `in_valid` gaps → identical address/data sequence, `sample_cnt` tracks accepts, and exactly one `fft_start`.
- `in_last` on sample 10 → `frame_err` pulses and no `fft_start`. The next 64 samples load from address 0 and start normally.
- 64 samples with no `in_last` → `frame_err` pulses with the write to address 63, and `fft_start` still pulses.
- `rst` = 0 after 30 samples → outputs return to reset values next cycle, no `wr_en` for the reset-cycle sample, and a fresh frame starts at address 0.
- `fft_done` asserted during LOAD, FLUSH and START is ignored. With `BITREV` = 0 the addresses are 0..63 in order.
